argmax_layer: RTL and testbench
===============================

ARGMAX_LAYER -- requirements
Module: argmax_layer

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32: width of each signed input element.
REQ-002 SHALL have parameter NUM_INPUTS, default 16: number of elements scanned; legal range 1..256.
REQ-003 SHALL have parameter THRESHOLD, default 0: signed DATA_WIDTH confidence threshold, used only under REQ-025.
REQ-004 SHALL derive localparam INDEX_WIDTH = max(1, clog2(NUM_INPUTS)).
REQ-005 SHALL have port clock  input  1  sole clock, all state updates on rising edge.
REQ-006 SHALL have port reset  input  1  synchronous, active-low reset.
REQ-007 SHALL have port inputs_ready  input  1  level from the upstream dense layer: its outputs are valid.
REQ-008 SHALL have port inputs  input  signed DATA_WIDTH x NUM_INPUTS array  upstream dense-layer outputs.
REQ-009 SHALL have port index  output  INDEX_WIDTH  position of the maximum element.
REQ-010 SHALL have port max_value  output  signed DATA_WIDTH  value of the maximum element.
REQ-011 SHALL have port output_ready  output  1  index/max_value valid.

Function
REQ-012 SHALL implement FSM states IDLE, SCAN, DONE.
REQ-013 SHALL register inputs_ready every cycle as ready_q; start = inputs_ready & ~ready_q (rising edge).
REQ-014 IDLE or DONE with start: capture all inputs into an internal buffer, best = inputs[0], index = 0, scan pointer = 1, output_ready = 0; go to SCAN (NUM_INPUTS>1) or DONE (NUM_INPUTS=1, output_ready = 1 on that same edge).
REQ-015 SCAN: one comparison per cycle, buffer[ptr] vs best, signed; replace best/index only if strictly greater (ties keep lowest index).
REQ-016 SCAN: at ptr = NUM_INPUTS-1, perform final compare, set output_ready = 1, go to DONE on the same edge; else ptr increments.
REQ-017 Latency: output_ready SHALL rise exactly NUM_INPUTS-1 rising edges after the capture edge.
REQ-018 SCAN SHALL ignore start and changes on inputs (buffered values only).
REQ-019 DONE SHALL hold index, max_value, output_ready=1 until a new start or reset.
REQ-020 inputs_ready held high continuously SHALL NOT retrigger; it must fall and rise again.
REQ-021 max_value SHALL equal best register; index and max_value are stable whenever output_ready = 1.

Reset
REQ-022 reset low at a rising edge SHALL force state IDLE, index = 0, max_value = 0, output_ready = 0, ready_q = 0, ptr = 0, from any state including mid-SCAN.
REQ-023 Because ready_q resets to 0, inputs_ready high on the first edge after reset release SHALL count as start.
REQ-024 Buffer contents need not reset; they SHALL never be observable before a capture.

Configuration
REQ-025 Macro ARGMAX_THRESHOLD_EN defined: SHALL add output port above_threshold  output  1, = (max_value >= THRESHOLD) signed, registered with output_ready, 0 in reset and whenever output_ready = 0.
REQ-026 Macro ARGMAX_THRESHOLD_EN undefined: port above_threshold and its logic SHALL be absent; all other behaviour identical.

Verification (DATA_WIDTH=16, NUM_INPUTS=4 unless stated)
REQ-027 inputs {3,-5,9,2}, inputs_ready 0->1 -> output_ready rises 3 edges after capture, index=2, max_value=9.
REQ-028 inputs {7,7,1,7} -> index=0, max_value=7 (tie keeps lowest index).
REQ-029 inputs {-8,-3,-3,-100} -> index=1, max_value=-3 (signed compare).
REQ-030 reset low one edge mid-SCAN -> IDLE, outputs 0; inputs_ready held high afterwards restarts only via REQ-023 edge, else stays IDLE.
REQ-031 DONE with inputs_ready held high, inputs changed to {0,0,0,50} -> outputs unchanged; inputs_ready 1->0->1 -> output_ready drops on capture edge, index=3, max_value=50 after 3 edges; NUM_INPUTS=1 with {5} -> output_ready on capture edge, index=0.
REQ-032 ARGMAX_THRESHOLD_EN, THRESHOLD=5: {1,2,4,3} -> above_threshold=0; {1,6,4,3} -> above_threshold=1 with output_ready.

Source files
------------

// File: rtl/argmax_layer.sv
// Sequential argmax over a buffered vector of signed dense-layer outputs, one compare per cycle.
// Define ARGMAX_THRESHOLD_EN to add the registered above_threshold confidence output.
module argmax_layer #(
  parameter int                            DATA_WIDTH  = 32,
  parameter int                            NUM_INPUTS  = 16,
  parameter logic signed [DATA_WIDTH-1:0]  THRESHOLD   = '0,
  localparam int                           INDEX_WIDTH = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          inputs_ready,
  input  logic signed [DATA_WIDTH-1:0]  inputs [NUM_INPUTS],
  output logic [INDEX_WIDTH-1:0]        index,
  output logic signed [DATA_WIDTH-1:0]  max_value,
`ifdef ARGMAX_THRESHOLD_EN
  output logic                          above_threshold,
`endif
  output logic                          output_ready
);

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

  localparam logic [INDEX_WIDTH-1:0] LAST_PTR = INDEX_WIDTH'(NUM_INPUTS - 1);

  state_t                         state_q;
  logic                           ready_q;
  logic [INDEX_WIDTH-1:0]         ptr_q;
  logic signed [DATA_WIDTH-1:0]   buf_q [NUM_INPUTS];

  logic                           start;
  logic                           scan_gt;
  logic signed [DATA_WIDTH-1:0]   best_d;
  logic [INDEX_WIDTH-1:0]         index_d;

  assign start = inputs_ready & ~ready_q;

  // Strictly-greater replacement keeps the lowest index on ties.
  always_comb begin
    scan_gt = buf_q[ptr_q] > max_value;
    best_d  = scan_gt ? buf_q[ptr_q] : max_value;
    index_d = scan_gt ? ptr_q : index;
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q      <= IDLE;
      ready_q      <= 1'b0;
      ptr_q        <= '0;
      index        <= '0;
      max_value    <= '0;
      output_ready <= 1'b0;
`ifdef ARGMAX_THRESHOLD_EN
      above_threshold <= 1'b0;
`endif
    end else begin
      ready_q <= inputs_ready;
      case (state_q)
        IDLE, DONE: begin
          if (start) begin
            buf_q        <= inputs;
            max_value    <= inputs[0];
            index        <= '0;
            ptr_q        <= INDEX_WIDTH'(1);
            output_ready <= (NUM_INPUTS == 1);
            state_q      <= (NUM_INPUTS == 1) ? DONE : SCAN;
`ifdef ARGMAX_THRESHOLD_EN
            above_threshold <= (NUM_INPUTS == 1) && (inputs[0] >= THRESHOLD);
`endif
          end
        end
        SCAN: begin
          max_value <= best_d;
          index     <= index_d;
          if (ptr_q == LAST_PTR) begin
            output_ready <= 1'b1;
            state_q      <= DONE;
`ifdef ARGMAX_THRESHOLD_EN
            above_threshold <= (best_d >= THRESHOLD);
`endif
          end else begin
            ptr_q <= ptr_q + INDEX_WIDTH'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_argmax_layer.sv
// Scoreboard bench for argmax_layer: 4-input and 1-input instances, 16-bit data, threshold 5.
module tb_argmax_layer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  logic                rdy4;
  logic signed [15:0]  in4 [4];
  logic [1:0]          idx4;
  logic signed [15:0]  max4;
  logic                or4;

  logic                rdy1;
  logic signed [15:0]  in1 [1];
  logic                idx1;
  logic signed [15:0]  max1;
  logic                or1;
`ifdef ARGMAX_THRESHOLD_EN
  logic                at4;
  logic                at1;
`endif

  argmax_layer #(.DATA_WIDTH(16), .NUM_INPUTS(4), .THRESHOLD(16'sd5)) u4 (
    .clock        (clk),
    .reset        (rst_n),
    .inputs_ready (rdy4),
    .inputs       (in4),
    .index        (idx4),
    .max_value    (max4),
`ifdef ARGMAX_THRESHOLD_EN
    .above_threshold (at4),
`endif
    .output_ready (or4)
  );

  argmax_layer #(.DATA_WIDTH(16), .NUM_INPUTS(1), .THRESHOLD(16'sd5)) u1 (
    .clock        (clk),
    .reset        (rst_n),
    .inputs_ready (rdy1),
    .inputs       (in1),
    .index        (idx1),
    .max_value    (max1),
`ifdef ARGMAX_THRESHOLD_EN
    .above_threshold (at1),
`endif
    .output_ready (or1)
  );

  typedef struct {
    int idx;
    int val;
    int due;
    int above;
  } exp_t;

  exp_t sb [$];
  exp_t mon_e;
  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;
  int   last_idx = 0;
  int   last_val = 0;
  logic prev_or  = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic signed [63:0] act, input logic signed [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  // Result monitor: each rising output_ready retires one scoreboard entry.
  always @(negedge clk) begin
    if (or4 === 1'b1 && !prev_or) begin
      if (sb.size() == 0) begin
        check_eq("unexpected_result", 1, 0);
      end else begin
        mon_e = sb.pop_front();
        check_eq("index", idx4, mon_e.idx);
        check_eq("max_value", max4, mon_e.val);
        check_eq("latency_cycle", cyc, mon_e.due);
`ifdef ARGMAX_THRESHOLD_EN
        check_eq("above_threshold", at4, mon_e.above);
`endif
      end
    end
    prev_or = (or4 === 1'b1);
  end

  function automatic int rnd16();
    logic signed [15:0] r;
    r = 16'($urandom);
    return int'(r);
  endfunction

  task automatic wait_done();
    int k = 0;
    while (or4 !== 1'b1 && k < 20) begin
      @(negedge clk);
      k++;
    end
    if (or4 !== 1'b1) check_eq("timeout_output_ready", 0, 1);
  endtask

  task automatic push_exp(input int v [4]);
    exp_t e;
    int   bi = 0;
    int   bv = v[0];
    for (int i = 1; i < 4; i++) begin
      if (v[i] > bv) begin
        bi = i;
        bv = v[i];
      end
    end
    e.idx   = bi;
    e.val   = bv;
    e.due   = cyc + 4;
    e.above = (bv >= 5) ? 1 : 0;
    sb.push_back(e);
    last_idx = bi;
    last_val = bv;
  endtask

  task automatic run_vec(input int a, input int b, input int c, input int d);
    int v [4];
    v = '{a, b, c, d};
    @(negedge clk);
    rdy4 = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 4; i++) in4[i] = 16'(v[i]);
    rdy4 = 1'b1;
    push_exp(v);
    @(negedge clk);
    check_eq("drop_on_capture", or4, 0);
    wait_done();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int v [4];
    rst_n = 1'b0;
    rdy4  = 1'b0;
    rdy1  = 1'b0;
    for (int i = 0; i < 4; i++) in4[i] = '0;
    in1[0] = '0;
    repeat (3) @(negedge clk);
    check_eq("reset_output_ready", or4, 0);
    check_eq("reset_index", idx4, 0);
    check_eq("reset_max_value", max4, 0);
    check_eq("reset_output_ready_n1", or1, 0);
`ifdef ARGMAX_THRESHOLD_EN
    check_eq("reset_above_threshold", at4, 0);
`endif
    rst_n = 1'b1;

    run_vec(3, -5, 9, 2);
    run_vec(7, 7, 1, 7);
    run_vec(-8, -3, -3, -100);
    run_vec(1, 2, 4, 3);
    run_vec(1, 6, 4, 3);
    run_vec(-32768, -32768, -32768, -32768);
    run_vec(32767, -1, 32767, 0);
    for (int n = 0; n < 4; n++) run_vec(rnd16(), rnd16(), rnd16(), rnd16());

    // DONE with inputs_ready held high: input changes must not retrigger.
    in4 = '{16'sd0, 16'sd0, 16'sd0, 16'sd50};
    repeat (5) @(negedge clk);
    check_eq("hold_output_ready", or4, 1);
    check_eq("hold_index", idx4, last_idx);
    check_eq("hold_max_value", max4, last_val);
    run_vec(0, 0, 0, 50);

    // Reset mid-scan with inputs_ready held high restarts via the post-reset edge.
    @(negedge clk);
    rdy4 = 1'b0;
    @(negedge clk);
    in4  = '{16'sd10, 16'sd20, 16'sd30, 16'sd40};
    rdy4 = 1'b1;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check_eq("midscan_reset_output_ready", or4, 0);
    check_eq("midscan_reset_index", idx4, 0);
    check_eq("midscan_reset_max_value", max4, 0);
    rst_n = 1'b1;
    v = '{10, 20, 30, 40};
    push_exp(v);
    wait_done();

    // Reset with inputs_ready low stays idle.
    @(negedge clk);
    rdy4  = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    check_eq("idle_after_reset_output_ready", or4, 0);
    check_eq("idle_after_reset_max_value", max4, 0);

    // Single-element instance: result on the capture edge.
    @(negedge clk);
    in1[0] = 16'sd5;
    rdy1   = 1'b1;
    @(negedge clk);
    check_eq("n1_output_ready", or1, 1);
    check_eq("n1_index", idx1, 0);
    check_eq("n1_max_value", max1, 5);
`ifdef ARGMAX_THRESHOLD_EN
    check_eq("n1_above_threshold", at1, 1);
`endif
    rdy1 = 1'b0;
    @(negedge clk);
    in1[0] = -16'sd7;
    rdy1   = 1'b1;
    @(negedge clk);
    check_eq("n1_second_output_ready", or1, 1);
    check_eq("n1_second_max_value", max1, -7);
`ifdef ARGMAX_THRESHOLD_EN
    check_eq("n1_second_above_threshold", at1, 0);
`endif

    repeat (3) @(negedge clk);
    check_eq("scoreboard_empty", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
